sdram_burst_arbiter: RTL and testbench

//  Shares the single SDRAM command port between three requesters: periodic refresh, write-FIFO

---
 rtl/sdram_burst_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sdram_burst_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_arbiter.sv
// Arbitrates the SDRAM command port between refresh, write-FIFO drain and read-FIFO fill,
// issuing one burst at a time and owning the frame write/read address pointers.
module sdram_burst_arbiter #(
  parameter int BURST_LEN   = 256,
  parameter int ADDR_W      = 22,
  parameter int FRAME_WORDS = 307200,
  parameter int REF_PERIOD  = 780
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_done,
  output logic              wr_frame_end,
  output logic              rd_frame_end,
  output logic              ref_overrun,
  output logic [1:0]        state_dbg
);

  // Handshake: a command transfers on a cycle where cmd_valid & cmd_ready are both high;
  // cmd_type/cmd_addr stay stable while cmd_valid is high and not yet accepted.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_REF  = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_RD   = 2'b11;

  localparam int                REF_W    = $clog2(REF_PERIOD);
  localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REF_PERIOD - 1);
  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_A  = ADDR_W'(FRAME_WORDS);

  // last_grant encoding: 1 = read, 0 = write
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic                ref_pend_q, ref_pend_d;
  logic                ref_overrun_q, ref_overrun_d;
  logic                rd_armed_q, rd_armed_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          cmd_type_q, cmd_type_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic                wr_frame_end_q, wr_frame_end_d;
  logic                rd_frame_end_q, rd_frame_end_d;

  logic                ref_wrap;
  logic                ref_accept;
  logic                wr_elig;
  logic                rd_elig;
  logic [ADDR_W-1:0]   wr_next;
  logic [ADDR_W-1:0]   rd_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ref_cnt_q      <= '0;
      ref_pend_q     <= 1'b0;
      ref_overrun_q  <= 1'b0;
      rd_armed_q     <= 1'b0;
      last_grant_q   <= 1'b1;
      cmd_type_q     <= CMD_NONE;
      cmd_addr_q     <= '0;
      wr_frame_end_q <= 1'b0;
      rd_frame_end_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ref_cnt_q      <= ref_cnt_d;
      ref_pend_q     <= ref_pend_d;
      ref_overrun_q  <= ref_overrun_d;
      rd_armed_q     <= rd_armed_d;
      last_grant_q   <= last_grant_d;
      cmd_type_q     <= cmd_type_d;
      cmd_addr_q     <= cmd_addr_d;
      wr_frame_end_q <= wr_frame_end_d;
      rd_frame_end_q <= rd_frame_end_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    ref_cnt_d      = ref_cnt_q;
    ref_pend_d     = ref_pend_q;
    ref_overrun_d  = ref_overrun_q;
    rd_armed_d     = rd_armed_q;
    last_grant_d   = last_grant_q;
    cmd_type_d     = cmd_type_q;
    cmd_addr_d     = cmd_addr_q;
    wr_frame_end_d = 1'b0;
    rd_frame_end_d = 1'b0;

    ref_wrap   = init_done && (ref_cnt_q == REF_LAST);
    ref_accept = (state_q == ISSUE) && cmd_ready && (cmd_type_q == CMD_REF);
    wr_elig    = wr_req;
    rd_elig    = rd_req && rd_armed_q;
    wr_next    = wr_ptr_q + BURST_A;
    rd_next    = rd_ptr_q + BURST_A;

    if (init_done) begin
      ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    end
    // A new period starting while the previous request is still unserved is an overrun;
    // a wrap coinciding with acceptance simply re-arms the request.
    if (ref_wrap) begin
      ref_pend_d = 1'b1;
      if (ref_pend_q && !ref_accept) begin
        ref_overrun_d = 1'b1;
      end
    end else if (ref_accept) begin
      ref_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (init_done) begin
          if (ref_pend_q) begin
            cmd_type_d = CMD_REF;
            cmd_addr_d = '0;
            state_d    = ISSUE;
          end else if (wr_elig && (!rd_elig || last_grant_q)) begin
            cmd_type_d   = CMD_WR;
            cmd_addr_d   = wr_ptr_q;
            last_grant_d = 1'b0;
            state_d      = ISSUE;
          end else if (rd_elig) begin
            cmd_type_d   = CMD_RD;
            cmd_addr_d   = rd_ptr_q;
            last_grant_d = 1'b1;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cmd_done) begin
          state_d    = IDLE;
          cmd_type_d = CMD_NONE;
          cmd_addr_d = '0;
          if (cmd_type_q == CMD_WR) begin
            rd_armed_d = 1'b1;
            if (wr_next == FRAME_A) begin
              wr_ptr_d       = '0;
              wr_frame_end_d = 1'b1;
            end else begin
              wr_ptr_d = wr_next;
            end
          end else if (cmd_type_q == CMD_RD) begin
            if (rd_next == FRAME_A) begin
              rd_ptr_d       = '0;
              rd_frame_end_d = 1'b1;
            end else begin
              rd_ptr_d = rd_next;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_valid    = (state_q == ISSUE);
  assign cmd_type     = cmd_type_q;
  assign cmd_addr     = cmd_addr_q;
  assign wr_frame_end = wr_frame_end_q;
  assign rd_frame_end = rd_frame_end_q;
  assign ref_overrun  = ref_overrun_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: init gating, round-robin, refresh priority,
// overrun detection and frame pointer wrap, with an expected-command queue.
module tb_sdram_burst_arbiter;

  localparam int BL     = 256;
  localparam int ADDR_W = 22;
  localparam int REF_P  = 780;

  logic              clk;
  logic              rst;
  logic              init_done;
  logic              wr_req;
  logic              rd_req;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_done;
  logic              wr_frame_end;
  logic              rd_frame_end;
  logic              ref_overrun;
  logic [1:0]        state_dbg;

  sdram_burst_arbiter #(
    .BURST_LEN   (BL),
    .ADDR_W      (ADDR_W),
    .FRAME_WORDS (307200),
    .REF_PERIOD  (REF_P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_done    (init_done),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_addr     (cmd_addr),
    .cmd_done     (cmd_done),
    .wr_frame_end (wr_frame_end),
    .rd_frame_end (rd_frame_end),
    .ref_overrun  (ref_overrun),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_fe_cnt = 0;
  int rd_fe_cnt = 0;
  logic [23:0] exp_q[$];

  always @(negedge clk) begin
    if (wr_frame_end) wr_fe_cnt++;
    if (rd_frame_end) rd_fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    init_done = 1'b0;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(cmd_valid), 32'd1);
  endtask

  task automatic accept_and_done(input int dly);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    repeat (dly) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
  endtask

  // Serves interleaved refreshes, then checks the next data command against the queue head.
  task automatic serve_next(input int dly, input string tag);
    logic [23:0] e;
    while (1) begin
      wait_valid(tag);
      if (cmd_valid !== 1'b1) break;
      if (cmd_type == 2'b01) begin
        check({tag, "_ref_addr"}, 32'(cmd_addr), 32'd0);
        accept_and_done(0);
      end else begin
        e = exp_q.pop_front();
        check(tag, 32'({cmd_type, cmd_addr}), 32'(e));
        accept_and_done(dly);
        break;
      end
    end
  endtask

  initial begin
    int seen;
    int stable;
    int fe_base;
    do_reset();
    #1;
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_type", 32'(cmd_type), 32'd0);
    check("rst_addr", 32'(cmd_addr), 32'd0);
    check("rst_frame_ends", 32'({wr_frame_end, rd_frame_end}), 32'd0);
    check("rst_overrun", 32'(ref_overrun), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // no activity before init_done
    wr_req = 1'b1;
    rd_req = 1'b1;
    seen = 0;
    repeat (2000) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) seen++;
    end
    check("no_cmd_before_init", 32'(seen), 32'd0);

    // read masked until the first write completes; first command must not be a refresh
    do_reset();
    init_done = 1'b1;
    rd_req    = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0) seen++;
    end
    check("rd_masked", 32'(seen), 32'd0);
    wr_req = 1'b1;
    exp_q.push_back({2'b10, 22'd0});
    exp_q.push_back({2'b11, 22'd0});
    exp_q.push_back({2'b10, 22'd256});
    exp_q.push_back({2'b11, 22'd256});
    exp_q.push_back({2'b10, 22'd512});
    exp_q.push_back({2'b11, 22'd512});
    for (int i = 0; i < 6; i++) serve_next(260, "rr_burst");
    check("rr_no_overrun", 32'(ref_overrun), 32'd0);

    // cmd_done in IDLE is ignored; request-to-valid latency is one cycle
    do_reset();
    init_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    repeat (3) @(negedge clk);
    wr_req = 1'b1;
    @(negedge clk);
    check("lat_valid", 32'(cmd_valid), 32'd1);
    check("lat_cmd", 32'({cmd_type, cmd_addr}), 32'({2'b10, 22'd0}));
    accept_and_done(2);
    exp_q.push_back({2'b10, 22'd256});
    serve_next(0, "after_stray_done");
    wr_req = 1'b0;

    // refresh due during a long write wins the next slot
    do_reset();
    init_done = 1'b1;
    wr_req    = 1'b1;
    exp_q.push_back({2'b10, 22'd0});
    serve_next(900, "long_wr");
    wait_valid("ref_first");
    check("ref_first_type", 32'(cmd_type), 32'd1);
    check("ref_first_addr", 32'(cmd_addr), 32'd0);
    accept_and_done(0);
    exp_q.push_back({2'b10, 22'd256});
    serve_next(0, "wr_after_ref");
    check("ref_no_overrun", 32'(ref_overrun), 32'd0);

    // stalled command: held stable, not withdrawn, and refresh overruns
    do_reset();
    init_done = 1'b1;
    wr_req    = 1'b1;
    wait_valid("stall");
    wr_req = 1'b0;
    stable = 0;
    repeat (2 * REF_P) begin
      @(negedge clk);
      if ({cmd_valid, cmd_type, cmd_addr} !== {1'b1, 2'b10, 22'd0}) stable++;
    end
    check("stall_stable", 32'(stable), 32'd0);
    check("stall_overrun", 32'(ref_overrun), 32'd1);
    accept_and_done(0);
    wait_valid("stall_ref");
    check("stall_ref_type", 32'(cmd_type), 32'd1);
    accept_and_done(0);
    check("overrun_sticky", 32'(ref_overrun), 32'd1);
    do_reset();
    #1;
    check("overrun_cleared", 32'(ref_overrun), 32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'd0);

    // full frame of writes wraps the pointer once
    init_done = 1'b1;
    wr_req    = 1'b1;
    fe_base   = wr_fe_cnt;
    for (int i = 0; i < 1200; i++) begin
      exp_q.push_back({2'b10, 22'(i * BL)});
      serve_next(0, "frame_wr");
      if (i == 1198) begin
        @(negedge clk);
        check("frame_end_early", 32'(wr_fe_cnt - fe_base), 32'd0);
      end
    end
    @(negedge clk);
    check("frame_end_once", 32'(wr_fe_cnt - fe_base), 32'd1);
    exp_q.push_back({2'b10, 22'd0});
    serve_next(0, "frame_wrapped_addr");
    check("rd_frame_end_quiet", 32'(rd_fe_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
